// File: rtl/dmem_pkg.sv
// Package: dmem_pkg
// Shared definitions for the data-memory load/store stage.
//  - state_t        : access FSM states (IDLE, ACCESS, DONE)
//  - DM_* constants : DMCtrl access-size encodings; unlisted codes behave as word
//  - align_lo       : forces the low address bits to the natural alignment of the size
//  - be_gen         : byte-enable pattern for a size and low address bits
//  - is_misaligned  : true when the address is not naturally aligned for the size
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  function automatic logic is_byte(input logic [2:0] ctrl);
    return (ctrl == DM_B) || (ctrl == DM_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] ctrl);
    return (ctrl == DM_H) || (ctrl == DM_HU);
  endfunction

  // Halfwords drop bit 0, words (and every unlisted code) drop bits 1:0.
  function automatic logic [1:0] align_lo(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    if (is_byte(ctrl))      return addr_lo;
    else if (is_half(ctrl)) return {addr_lo[1], 1'b0};
    else                    return 2'b00;
  endfunction

  function automatic logic [3:0] be_gen(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    if (is_byte(ctrl))      return 4'b0001 << addr_lo;
    else if (is_half(ctrl)) return 4'b0011 << {addr_lo[1], 1'b0};
    else                    return 4'b1111;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    return align_lo(ctrl, addr_lo) != addr_lo;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Module: load_extend
// Combinational lane select and sign/zero extension of a RAM read word.
// Ports:
//  rdata   in  32  word returned by the RAM
//  ctrl    in  3   DMCtrl access size (B/H sign-extend, BU/HU zero-extend, else word)
//  addr_lo in  2   already-aligned low address bits choosing the lane
//  data    out 32  extended load value
module load_extend (
  input  logic [31:0] rdata,
  input  logic [2:0]  ctrl,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);
  import dmem_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ctrl)
      DM_B:    data = {{24{byte_v[7]}}, byte_v};
      DM_BU:   data = {24'h0, byte_v};
      DM_H:    data = {{16{half_v[15]}}, half_v};
      DM_HU:   data = {16'h0, half_v};
      DM_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Module: data_mem_unit
// Load/store stage between the ALU result and the write-back mux. Issues byte,
// halfword and word accesses to an external data RAM over a MemReq/MemAck
// handshake, returns extended load data on DataRd and stalls the core via Busy.
// Parameters: ADDR_W (byte-address width), TIMEOUT_CYCLES (ACCESS cycles before abort, >=2).
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses with
// Err instead of silently aligning them.
// Ports:
//  CLK, RESET                         clock, synchronous active-high reset
//  MemRd, MemWr, DMCtrl, Addr, DataIn core-side request (sampled in IDLE)
//  DataRd, Busy, Done, Err            core-side results
//  MemReq, MemWe, MemAddr, MemBE,     RAM request, stable while MemReq is high
//  MemWData
//  MemAck, MemRData                   RAM completion and read word
module data_mem_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [2:0]        DMCtrl,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataRd,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [3:0]        MemBE,
  output logic [31:0]       MemWData,
  input  logic              MemAck,
  input  logic [31:0]       MemRData
);
  import dmem_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_data;
  logic [2:0]        lat_ctrl;
  logic              lat_we;
  logic [CNT_W-1:0]  cnt;
  logic              req_r;
  logic              done_r;
  logic              err_r;
  logic [31:0]       data_rd_r;
  logic [31:0]       ext_data;
  logic [1:0]        eff_lo;
  logic              trap;

  // Without the trap the low bits are simply forced to natural alignment.
  assign eff_lo = align_lo(lat_ctrl, lat_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(DMCtrl, Addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata   (MemRData),
    .ctrl    (lat_ctrl),
    .addr_lo (eff_lo),
    .data    (ext_data)
  );

  // Access FSM: IDLE latches a request, ACCESS waits for the ack or the
  // timeout, DONE pulses Done for exactly one cycle before returning to IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_ctrl  <= '0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      req_r     <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      data_rd_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          err_r <= 1'b0;
          if (MemRd || MemWr) begin
            lat_addr <= Addr;
            lat_data <= DataIn;
            lat_ctrl <= DMCtrl;
            lat_we   <= MemWr;
            cnt      <= '0;
            if (trap) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else begin
              state <= ST_ACCESS;
              req_r <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + 1'b1;
          // An ack in the final counted cycle still completes normally.
          if (MemAck) begin
            state  <= ST_DONE;
            req_r  <= 1'b0;
            done_r <= 1'b1;
            err_r  <= 1'b0;
            if (!lat_we) data_rd_r <= ext_data;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_DONE;
            req_r  <= 1'b0;
            done_r <= 1'b1;
            err_r  <= 1'b1;
            if (!lat_we) data_rd_r <= '0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          err_r <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          req_r <= 1'b0;
          err_r <= 1'b0;
        end
      endcase
    end
  end

  // Store data is replicated into every lane so the RAM only needs the enables.
  always_comb begin
    if (is_byte(lat_ctrl))      MemWData = {4{lat_data[7:0]}};
    else if (is_half(lat_ctrl)) MemWData = {2{lat_data[15:0]}};
    else                        MemWData = lat_data;
  end

  assign MemBE   = be_gen(lat_ctrl, eff_lo);
  assign MemAddr = {lat_addr[ADDR_W-1:2], 2'b00};
  assign MemWe   = lat_we;
  assign MemReq  = req_r;
  assign Done    = done_r;
  assign Err     = err_r;
  assign DataRd  = data_rd_r;

  // The core must stall in the very cycle it raises a request.
  assign Busy = (state == ST_ACCESS) || ((state == ST_IDLE) && (MemRd || MemWr));

endmodule

// File: tb/tb_data_mem_unit.sv
// Testbench: tb_data_mem_unit
// Directed cases followed by randomized loads and stores, all checked against a
// byte-level reference model of sizes, lanes and extension.
// Honours MISALIGN_TRAP_EN when compiled with the same define as the design.
module tb_data_mem_unit;

  localparam int T = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [2:0]  DMCtrl = 3'b000;
  logic [31:0] Addr = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataRd;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBE;
  logic [31:0] MemWData;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = '0;

  int assertCount = 0;
  int failCount = 0;
  logic [31:0] expDataRd = '0;

  data_mem_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RESET(RESET), .MemRd(MemRd), .MemWr(MemWr), .DMCtrl(DMCtrl),
    .Addr(Addr), .DataIn(DataIn), .DataRd(DataRd), .Busy(Busy), .Done(Done),
    .Err(Err), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBE(MemBE),
    .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData)
  );

  always #5 CLK = ~CLK;

  // Hard stop in case something stalls the stimulus
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: access size in bytes, signedness, lane offset, enables,
  // replicated write data and extended load value from plain arithmetic.
  function automatic int unsigned sizeOf(input logic [2:0] c);
    if (c == 3'b000 || c == 3'b100) return 1;
    if (c == 3'b001 || c == 3'b101) return 2;
    return 4;
  endfunction

  function automatic int unsigned laneOf(input logic [2:0] c, input logic [31:0] a);
    int unsigned sz = sizeOf(c);
    int unsigned o = a % 4;
    return o - (o % sz);
  endfunction

  function automatic bit trapExpected(input logic [2:0] c, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (a % sizeOf(c)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] c, input logic [31:0] a);
    int unsigned m = (1 << sizeOf(c)) - 1;
    return 4'(m << laneOf(c, a));
  endfunction

  function automatic logic [31:0] modelWData(input logic [2:0] c, input logic [31:0] d);
    logic [31:0] r = '0;
    int unsigned sz = sizeOf(c);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(d >> (8 * (i % sz)));
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] rd);
    int unsigned sz = sizeOf(c);
    logic [31:0] v = rd >> (8 * laneOf(c, a));
    bit sgn = (c == 3'b000) || (c == 3'b001);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // One complete transaction. ackDelay counts ACCESS cycles before the ack
  // (0 = ack in the first ACCESS cycle); ackDelay >= T means no ack at all.
  task automatic applyStimulus(input string tag, input bit we, input logic [2:0] c,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] rd, input int ackDelay);
    bit trap = trapExpected(c, a);
    bit fin = 1'b0;
    bit expErr;
    int k = 0;
    int busyCycles = 0;
    MemRd = !we; MemWr = we; DMCtrl = c; Addr = a; DataIn = d;
    #2;
    checkOutput({tag, "_busy_req"}, 32'(Busy), 32'd1);
    busyCycles++;
    nextCycle();
    MemRd = 1'b0; MemWr = 1'b0;
    DMCtrl = 3'($urandom); Addr = $urandom; DataIn = $urandom;
    if (trap) begin
      expErr = 1'b1;
    end else begin
      expErr = (ackDelay >= T);
      while (!fin && k < T) begin
        if (k == ackDelay) begin
          MemAck = 1'b1;
          MemRData = rd;
        end
        #2;
        checkOutput({tag, "_req"}, 32'(MemReq), 32'd1);
        checkOutput({tag, "_we"}, 32'(MemWe), 32'(we));
        checkOutput({tag, "_addr"}, MemAddr, {a[31:2], 2'b00});
        checkOutput({tag, "_be"}, 32'(MemBE), 32'(modelBe(c, a)));
        if (we) checkOutput({tag, "_wdata"}, MemWData, modelWData(c, d));
        checkOutput({tag, "_done_early"}, 32'(Done), 32'd0);
        if (Busy) busyCycles++;
        fin = (k == ackDelay) || (k == T - 1);
        nextCycle();
        MemAck = 1'b0;
        MemRData = $urandom;
        k++;
      end
      if (!we) expDataRd = expErr ? 32'h0 : modelLoad(c, a, rd);
      checkOutput({tag, "_busy_cycles"}, 32'(busyCycles),
                  32'(1 + ((ackDelay >= T) ? T : ackDelay + 1)));
    end
    #2;
    checkOutput({tag, "_done"}, 32'(Done), 32'd1);
    checkOutput({tag, "_err"}, 32'(Err), 32'(expErr));
    checkOutput({tag, "_req_done"}, 32'(MemReq), 32'd0);
    checkOutput({tag, "_busy_done"}, 32'(Busy), 32'd0);
    checkOutput({tag, "_datard"}, DataRd, expDataRd);
    nextCycle();
    #2;
    checkOutput({tag, "_done_pulse"}, 32'(Done), 32'd0);
  endtask

  initial begin
    nextCycle();
    nextCycle();
    #2;
    checkOutput("rst_req", 32'(MemReq), 32'd0);
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    checkOutput("rst_done", 32'(Done), 32'd0);
    checkOutput("rst_err", 32'(Err), 32'd0);
    checkOutput("rst_datard", DataRd, 32'd0);
    RESET = 1'b0;
    nextCycle();

    // Ack while idle must be ignored
    MemAck = 1'b1; MemRData = 32'hCAFEF00D;
    nextCycle();
    MemAck = 1'b0;
    #2;
    checkOutput("idle_ack_done", 32'(Done), 32'd0);
    checkOutput("idle_ack_datard", DataRd, 32'd0);
    nextCycle();

    applyStimulus("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    applyStimulus("sh", 1'b1, 3'b001, 32'h22, 32'hDEADBEEF, 32'h0, 0);
    applyStimulus("lhu", 1'b0, 3'b101, 32'h40, 32'h0, 32'h0000F00D, 4);
    applyStimulus("lw_timeout", 1'b0, 3'b010, 32'h80, 32'h0, 32'h12345678, T);
    applyStimulus("lw_mis", 1'b0, 3'b010, 32'h6, 32'h0, 32'hA5A5_1234, 1);

    // Reset in the middle of an access followed by a late ack
    MemRd = 1'b1; DMCtrl = 3'b010; Addr = 32'h200;
    nextCycle();
    MemRd = 1'b0;
    nextCycle();
    #2;
    checkOutput("rstmid_req_before", 32'(MemReq), 32'd1);
    RESET = 1'b1;
    nextCycle();
    RESET = 1'b0; MemAck = 1'b1; MemRData = 32'h13579BDF;
    #2;
    checkOutput("rstmid_req", 32'(MemReq), 32'd0);
    checkOutput("rstmid_datard", DataRd, 32'd0);
    expDataRd = '0;
    nextCycle();
    MemAck = 1'b0;
    #2;
    checkOutput("rstmid_done", 32'(Done), 32'd0);
    checkOutput("rstmid_req2", 32'(MemReq), 32'd0);
    nextCycle();
    #2;
    checkOutput("rstmid_done2", 32'(Done), 32'd0);
    checkOutput("rstmid_datard2", DataRd, 32'd0);

    // Randomized mix of loads and stores over all control codes
    for (int n = 0; n < 60; n++) begin
      bit we = 1'($urandom);
      logic [2:0] c = 3'($urandom);
      int dly = $urandom_range(0, 5);
      if (!we && ($urandom_range(0, 9) == 0)) dly = T;
      applyStimulus("rnd", we, c, $urandom, $urandom, $urandom, dly);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
